// File: rtl/div_arbiter_pkg.sv
// Shared types for the Falco divider arbiter: operand width, divide op encoding,
// arbiter state encoding and the optional result-reuse entry.
package Falco_pkg;

  localparam int XLEN_WIDTH = 32;
  typedef logic [XLEN_WIDTH-1:0] xlen_data_t;

  localparam int NUM_DIV_REQ = 2;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DRAIN = 2'b11
  } div_arb_state_e;

  typedef struct packed {
    xlen_data_t a;
    xlen_data_t b;
    div_op_e    op;
    xlen_data_t result;
    logic       valid;
  } div_reuse_entry_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider handshake bundle for div_arbiter. The slave modport is
// the arbiter's view; master is the requesters plus the divider.
interface div_arbiter_if #(
  parameter int NUM_REQ = Falco_pkg::NUM_DIV_REQ
) ();
  import Falco_pkg::*;

  logic [NUM_REQ-1:0]            req_i;
  xlen_data_t [NUM_REQ-1:0]      a_i;
  xlen_data_t [NUM_REQ-1:0]      b_i;
  logic [NUM_REQ-1:0][1:0]       op_i;
  logic [NUM_REQ-1:0]            kill_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic [NUM_REQ-1:0]            result_valid_o;
  xlen_data_t                    result_o;
  logic                          busy_o;
  logic                          div_req_o;
  logic                          div_kill_o;
  xlen_data_t                    div_a_o;
  xlen_data_t                    div_b_o;
  logic [1:0]                    div_op_o;
  logic                          div_stall_o;
  logic                          div_ready_i;
  logic                          div_result_valid_i;
  xlen_data_t                    div_result_i;

  modport slave (
    input  req_i, a_i, b_i, op_i, kill_i,
    input  div_ready_i, div_result_valid_i, div_result_i,
    output grant_o, result_valid_o, result_o, busy_o,
    output div_req_o, div_kill_o, div_a_o, div_b_o, div_op_o, div_stall_o
  );

  modport master (
    output req_i, a_i, b_i, op_i, kill_i,
    output div_ready_i, div_result_valid_i, div_result_i,
    input  grant_o, result_valid_o, result_o, busy_o,
    input  div_req_o, div_kill_o, div_a_o, div_b_o, div_op_o, div_stall_o
  );

endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, priority pointer moves
// to the lane after the grantee whenever advance_i is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;

  // Indices never exceed 2N-1, so a single subtraction wraps them.
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[IdxW'(wrap(int'(ptr_q) + i))]) begin
        found                                    = 1'b1;
        grant_o[IdxW'(wrap(int'(ptr_q) + i))]    = 1'b1;
        ptr_d                                    = IdxW'(wrap(int'(ptr_q) + i + 1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between NUM_REQ requesters: round-robin grant,
// kill forwarding with drain, per-owner result pulse. Optional DIV_ARB_REUSE_EN.
module div_arbiter
  import Falco_pkg::*;
#(
  parameter int NUM_REQ = NUM_DIV_REQ
) (
  input logic           clk_i,
  input logic           rst_i,
  div_arbiter_if.slave  bus
);

  div_arb_state_e       state_q;
  logic [NUM_REQ-1:0]   owner_q;
  logic [NUM_REQ-1:0]   result_valid_q;
  xlen_data_t           result_q;
  logic                 div_req_q;
  logic                 div_kill_q;
  xlen_data_t           div_a_q;
  xlen_data_t           div_b_q;
  div_op_e              div_op_q;
  logic                 kill_pend_q;
  logic                 drain_first_q;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic                 advance;
  logic                 kill_now;
  xlen_data_t           sel_a;
  xlen_data_t           sel_b;
  logic [1:0]           sel_op;
  logic                 reuse_hit;
  xlen_data_t           reuse_result;

  assign eligible = bus.req_i & ~bus.kill_i;
  assign advance  = !rst_i && (state_q == S_IDLE) && bus.div_ready_i && (|eligible);
  assign kill_now = kill_pend_q || (|(bus.kill_i & owner_q));

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (eligible),
    .advance_i (advance),
    .grant_o   (rr_gnt)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_gnt[k]) begin
        sel_a  = bus.a_i[k];
        sel_b  = bus.b_i[k];
        sel_op = bus.op_i[k];
      end
    end
  end

`ifdef DIV_ARB_REUSE_EN
  div_reuse_entry_t entry_q;
  logic             deliver;

  assign deliver      = (state_q == S_WAIT) && !kill_now && bus.div_result_valid_i;
  assign reuse_hit    = entry_q.valid && (entry_q.a == sel_a) && (entry_q.b == sel_b)
                        && (entry_q.op == div_op_e'(sel_op));
  assign reuse_result = entry_q.result;

  // Only the valid bit needs reset; the payload is ignored while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q.valid <= 1'b0;
    end else if (deliver) begin
      entry_q <= '{a: div_a_q, b: div_b_q, op: div_op_q,
                   result: bus.div_result_i, valid: 1'b1};
    end
  end
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      result_valid_q <= '0;
      result_q       <= '0;
      div_req_q      <= 1'b0;
      div_kill_q     <= 1'b0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      div_op_q       <= DIV_OP_DIV;
      kill_pend_q    <= 1'b0;
      drain_first_q  <= 1'b0;
    end else begin
      result_valid_q <= '0;
      div_kill_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (advance) begin
            owner_q <= rr_gnt;
            if (reuse_hit) begin
              result_q       <= reuse_result;
              result_valid_q <= rr_gnt;
            end else begin
              div_a_q     <= sel_a;
              div_b_q     <= sel_b;
              div_op_q    <= div_op_e'(sel_op);
              div_req_q   <= 1'b1;
              kill_pend_q <= 1'b0;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // The request is already on its way; a kill here is honoured next cycle.
          div_req_q   <= 1'b0;
          kill_pend_q <= |(bus.kill_i & owner_q);
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (kill_now) begin
            div_kill_q    <= 1'b1;
            kill_pend_q   <= 1'b0;
            drain_first_q <= 1'b1;
            state_q       <= S_DRAIN;
          end else if (bus.div_result_valid_i) begin
            result_q       <= bus.div_result_i;
            result_valid_q <= owner_q;
            state_q        <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // The first cycle's ready is stale: the divider has not yet seen the kill.
          drain_first_q <= 1'b0;
          if (!drain_first_q && bus.div_ready_i && !bus.div_result_valid_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant_o        = advance ? rr_gnt : '0;
  assign bus.result_valid_o = result_valid_q;
  assign bus.result_o       = result_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.div_req_o      = div_req_q;
  assign bus.div_kill_o     = div_kill_q;
  assign bus.div_a_o        = div_a_q;
  assign bus.div_b_o        = div_b_q;
  assign bus.div_op_o       = div_op_q;
  assign bus.div_stall_o    = 1'b0;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares the single multi-cycle `divider` between `NUM_REQ` requesters, such as the issue lanes of the Falco execute stage. It arbitrates requests round-robin and issues exactly one divide at a time. It forwards kills to the divider, drains any aborted operation, and routes each result back to the requester that owns it as a single-cycle pulse.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; must be ≥ 2.

Ports. Clock is `clk_i`; reset is `rst_i`, synchronous and active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `req_i`  in  NUM_REQ  per-requester request; held until granted or killed
- `a_i`, `b_i`  in  NUM_REQ×XLEN_WIDTH  dividend and divisor per requester
- `op_i`  in  NUM_REQ×2  operation per requester, `div_op_e`: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `kill_i`  in  NUM_REQ  per-requester kill; aborts that requester's pending or in-flight operation
- `grant_o`  out  NUM_REQ  one-hot, one-cycle pulse; operands are captured this cycle
- `result_valid_o`  out  NUM_REQ  one-hot, one-cycle pulse to the owning requester
- `result_o`  out  XLEN_WIDTH  shared result bus; meaningful only while `result_valid_o` is asserted
- `busy_o`  out  1  high whenever the arbiter is not in S_IDLE
- `div_req_o`, `div_kill_o`  out  1  request and kill to the divider
- `div_a_o`, `div_b_o`  out  XLEN_WIDTH  registered operands to the divider
- `div_op_o`  out  2  operation to the divider
- `div_stall_o`  out  1  tied to 0; requesters always accept results
- `div_ready_i`, `div_result_valid_i`  in  1  divider handshake inputs
- `div_result_i`  in  XLEN_WIDTH  divider result

## Operation
State machine: S_IDLE → S_ISSUE → S_WAIT → S_IDLE. A kill diverts S_WAIT to S_DRAIN → S_IDLE.

- **S_IDLE**
  - Eligible requesters are those with `req_i[k] & ~kill_i[k]`.
  - When `div_ready_i` is high and at least one requester is eligible, grant exactly one of them round-robin. Search starts at the index after the last grantee; after reset, lane 0 has highest priority.
  - On grant, pulse `grant_o[k]`, latch the owner index, and latch `a`, `b` and `op` into the `div_*_o` registers. Go to S_ISSUE.
- **S_ISSUE**: `div_req_o` is 1 for exactly this cycle. Go to S_WAIT.
- **S_WAIT**
  - On `div_result_valid_i`: register `div_result_i` into `result_o` and pulse `result_valid_o[owner]` on the next cycle. Go to S_IDLE.
  - If `kill_i[owner]` is asserted (this takes priority over a same-cycle `div_result_valid_i`): drive `div_kill_o` for one cycle, drop the result, and go to S_DRAIN.
- **S_DRAIN**
  - Discard any `div_result_valid_i`.
  - Leave for S_IDLE on the first cycle where `div_ready_i` is 1 and `div_result_valid_i` is 0, counting from the second S_DRAIN cycle onward.
- **Kill rules**
  - A kill to a non-owner lane only blocks that lane from being granted.
  - A kill in the same cycle as a candidate grant suppresses that grant.
  - A kill during S_ISSUE is registered and acted on in the first S_WAIT cycle.
- **Operands**: `a_i`, `b_i` and `op_i` are don't-care after the grant; the arbiter never re-reads them.
- **Divide by zero**: zero-operand cases are passed through unchanged; the divider's special values (quotient all-ones, remainder = a) are returned as-is.

## Timing
- Reset values: all outputs 0; state S_IDLE; round-robin pointer set so lane 0 has priority; reuse entry (when configured) invalid.
- Latency:
  - Grant at cycle G, `div_req_o` at G+1.
  - `result_valid_o` arrives exactly 1 cycle after `div_result_valid_i`.
  - For a nonzero divide: G+1 plus the divider latency plus 1.
- Throughput: at most one operation in flight. The next grant happens at the earliest on the first S_IDLE cycle with `div_ready_i` high.
- Reset mid-operation: the arbiter returns to S_IDLE on the next cycle. The divider shares `rst_i`, and no `result_valid_o` pulse is produced.
- Requesters must hold `req_i` until `grant_o` or `kill_i`. Dropping `req_i` before grant is legal and cancels the request.

## Configuration
- `DIV_ARB_REUSE_EN`
  - **Defined**: keep one entry `{a, b, op, result, valid}`, written on every delivered, non-killed result.
    - A grant in S_IDLE whose `a`, `b` and `op` exactly match a valid entry bypasses the divider: `result_o` = the stored result and `result_valid_o` pulses at G+1. The state stays S_IDLE and no `div_req_o` is issued.
    - The entry is invalidated by reset.
  - **Undefined**: the entry logic is absent, and every grant goes through S_ISSUE.

## Structure
- `Falco_pkg` holds:
  - `xlen_data_t` and `XLEN_WIDTH` (existing)
  - new `div_op_e` (2-bit, encoding as above)
  - new `NUM_DIV_REQ` default
  - the state enum `div_arb_state_e`
- Sub-module `rr_arbiter`: parameterised N-way round-robin arbiter with `req`, `advance` and one-hot `grant` ports. It is also reusable for other shared execute resources.

## Test plan
- **Single requester:** lane 0 requests DIV with a=100, b=7 → `grant_o`=01, then `div_req_o` one cycle later, then `result_valid_o`=01 with `result_o`=14 one cycle after the divider's result-valid pulse.
- **Fairness:** both lanes hold `req_i` continuously with REMU 17/5 → grants alternate lane 0, lane 1, lane 0. Each lane receives `result_o`=2, with no duplicate or missing pulses.
- **Kill in flight:** lane 1 DIVU 0xFFFFFFFF/3 is killed 10 cycles after issue → `div_kill_o` pulses for one cycle, and lane 1 never sees `result_valid_o`. A subsequent lane 0 request for 9/3 returns 3.
- **Divide by zero:** DIV 5/0 → returns 0xFFFFFFFF. REM -8/0 → returns 0xFFFFFFF8 (−8, i.e. a).
- **Reuse (`DIV_ARB_REUSE_EN` defined):** lane 0 DIV -20/3 → returns -6. The identical request then returns -6 at G+1 with `div_req_o` staying 0. A following REM -20/3 uses the divider and returns -2.
- **Reset mid-operation:** assert `rst_i` during S_WAIT → all outputs are 0 on the next cycle, there is no stale `result_valid_o`, and the first grant afterwards goes to lane 0.
